// File: rtl/priority_sensor_ctrl.sv
// priority_sensor_ctrl
//   Multi-channel sensor event latch with a priority interrupt. Every channel
//   latches an event (a level or a rising edge) into a pending bit. The block
//   reports one interrupt line plus the ID of the lowest-numbered pending
//   channel that is not masked. Pending bits are cleared by acknowledge-by-ID
//   or by a per-channel clear. Sticky overrun flags record events that arrive
//   while the channel is already pending.
//
// Parameters
//   NCH   number of sensor channels (2..32)
//   IDW   channel ID width, ceil(log2(NCH))
//   EDGE  0 = level detection, 1 = rising-edge detection
//
// Ports
//   clk        clock, all state updates on the rising edge
//   grst       synchronous active-high reset; also forces interrupt/irq_id low
//   sensor     raw sensor inputs, already synchronous to clk
//   mask       1 = channel excluded from interrupt/irq_id (it still latches)
//   clr        per-channel clear of pending
//   ack        clear the channel currently reported on irq_id
//   ovr_clr    clear all overrun flags
//   interrupt  OR of (pending & ~mask)
//   irq_id     lowest-numbered pending unmasked channel, 0 when none
//   pending    per-channel latched state
//   overrun    sticky per-channel overrun flags
module priority_sensor_ctrl #(
    parameter int unsigned NCH  = 8,
    parameter int unsigned IDW  = 3,
    parameter int unsigned EDGE = 0
) (
    input  logic           clk,
    input  logic           grst,
    input  logic [NCH-1:0] sensor,
    input  logic [NCH-1:0] mask,
    input  logic [NCH-1:0] clr,
    input  logic           ack,
    input  logic           ovr_clr,
    output logic           interrupt,
    output logic [IDW-1:0] irq_id,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] overrun
);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_ACT  = 1'b1
    } ch_state_t;

    ch_state_t      state_q [NCH];
    ch_state_t      state_d [NCH];

    logic [NCH-1:0] sensor_d;
    logic [NCH-1:0] overrun_q;
    logic [NCH-1:0] overrun_d;
    logic [NCH-1:0] ev;
    logic [NCH-1:0] cl;
    logic [NCH-1:0] qual;
    logic           any_qual;
    logic [IDW-1:0] first_id;

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    // sensor_d resets to 0, so in edge mode an input already high when
    // reset is released is seen as a rising edge on the first live cycle.
    always_comb begin
        if (EDGE != 0) begin
            ev = sensor & ~sensor_d;
        end else begin
            ev = sensor;
        end
    end

    // ------------------------------------------------------------------
    // Priority selection (registered state plus mask/grst only)
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            pending[i] = (state_q[i] == CH_ACT);
        end
    end

    assign qual = pending & ~mask;

    always_comb begin
        any_qual = 1'b0;
        first_id = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!any_qual && qual[i]) begin
                any_qual = 1'b1;
                first_id = IDW'(i);
            end
        end
    end

    assign interrupt = any_qual & ~grst;
    assign irq_id    = grst ? '0 : first_id;

    // ------------------------------------------------------------------
    // Per-channel clear: explicit clear, or ack of the reported channel.
    // Gating ack with interrupt makes an ack with nothing reported a no-op.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cl[i] = clr[i] | (ack & interrupt & (irq_id == IDW'(i)));
        end
    end

    // ------------------------------------------------------------------
    // Channel FSMs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (grst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= CH_IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // A clear wins over a coincident event on an active channel; an idle
    // channel ignores clear and arms on an event.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                CH_IDLE: if (ev[i]) state_d[i] = CH_ACT;
                CH_ACT:  if (cl[i]) state_d[i] = CH_IDLE;
                default: state_d[i] = CH_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Overrun flags: a new set beats ovr_clr for the same bit
    // ------------------------------------------------------------------
    always_comb begin
        overrun_d = ovr_clr ? '0 : overrun_q;
        overrun_d = overrun_d | (pending & ev & ~cl);
    end

    always_ff @(posedge clk) begin
        if (grst) begin
            overrun_q <= '0;
            sensor_d  <= '0;
        end else begin
            overrun_q <= overrun_d;
            sensor_d  <= sensor;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_priority_sensor_ctrl.sv
// Directed bench for priority_sensor_ctrl. It uses two instances, one in level
// mode (u_lvl) and one in edge mode (u_edg). Expected results are queued
// before the stimulus takes effect and checked when the outputs are sampled.
module tb_priority_sensor_ctrl;

    logic       clk = 1'b0;
    logic       grst;

    logic [7:0] a_sensor, a_mask, a_clr;
    logic       a_ack, a_ovr_clr;
    logic       a_interrupt;
    logic [2:0] a_irq_id;
    logic [7:0] a_pending, a_overrun;

    logic [7:0] b_sensor, b_mask, b_clr;
    logic       b_ack, b_ovr_clr;
    logic       b_interrupt;
    logic [2:0] b_irq_id;
    logic [7:0] b_pending, b_overrun;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        bit         dut;
        logic [7:0] pend;
        logic [7:0] ovr;
        logic       intr;
        logic [2:0] id;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    priority_sensor_ctrl #(.NCH(8), .IDW(3), .EDGE(0)) u_lvl (
        .clk(clk), .grst(grst), .sensor(a_sensor), .mask(a_mask), .clr(a_clr),
        .ack(a_ack), .ovr_clr(a_ovr_clr), .interrupt(a_interrupt),
        .irq_id(a_irq_id), .pending(a_pending), .overrun(a_overrun)
    );

    priority_sensor_ctrl #(.NCH(8), .IDW(3), .EDGE(1)) u_edg (
        .clk(clk), .grst(grst), .sensor(b_sensor), .mask(b_mask), .clr(b_clr),
        .ack(b_ack), .ovr_clr(b_ovr_clr), .interrupt(b_interrupt),
        .irq_id(b_irq_id), .pending(b_pending), .overrun(b_overrun)
    );

    task automatic cmp(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic exp_a(input string tag, input logic [7:0] p, input logic [7:0] o,
                         input logic i, input logic [2:0] id);
        sb.push_back('{tag, 1'b0, p, o, i, id});
    endtask

    task automatic exp_b(input string tag, input logic [7:0] p, input logic [7:0] o,
                         input logic i, input logic [2:0] id);
        sb.push_back('{tag, 1'b1, p, o, i, id});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut) begin
                cmp(e.tag, "pending",   b_pending,   e.pend);
                cmp(e.tag, "overrun",   b_overrun,   e.ovr);
                cmp(e.tag, "interrupt", {7'b0, b_interrupt}, {7'b0, e.intr});
                cmp(e.tag, "irq_id",    {5'b0, b_irq_id},    {5'b0, e.id});
            end else begin
                cmp(e.tag, "pending",   a_pending,   e.pend);
                cmp(e.tag, "overrun",   a_overrun,   e.ovr);
                cmp(e.tag, "interrupt", {7'b0, a_interrupt}, {7'b0, e.intr});
                cmp(e.tag, "irq_id",    {5'b0, a_irq_id},    {5'b0, e.id});
            end
        end
    endtask

    // advance one edge, then check away from it
    task automatic cyc();
        @(posedge clk);
        #1;
        drain();
    endtask

    // check combinational outputs without a clock edge
    task automatic settle();
        #1;
        drain();
    endtask

    initial begin
        grst = 1'b1;
        a_sensor = 8'hFF; a_mask = '0; a_clr = '0; a_ack = 1'b0; a_ovr_clr = 1'b0;
        b_sensor = 8'hFF; b_mask = '0; b_clr = '0; b_ack = 1'b0; b_ovr_clr = 1'b0;

        // reset held with all sensors high
        exp_a("rst1", 8'h00, 8'h00, 1'b0, 3'd0); exp_b("rst1", 8'h00, 8'h00, 1'b0, 3'd0);
        cyc();
        exp_a("rst2", 8'h00, 8'h00, 1'b0, 3'd0); exp_b("rst2", 8'h00, 8'h00, 1'b0, 3'd0);
        cyc();
        grst = 1'b0;
        exp_a("rel0", 8'h00, 8'h00, 1'b0, 3'd0); exp_b("rel0", 8'h00, 8'h00, 1'b0, 3'd0);
        settle();
        // both modes register the held-high inputs on the first live edge
        exp_a("rel1", 8'hFF, 8'h00, 1'b1, 3'd0); exp_b("rel1", 8'hFF, 8'h00, 1'b1, 3'd0);
        cyc();
        a_sensor = '0; b_sensor = '0; a_clr = 8'hFF; b_clr = 8'hFF;
        exp_a("clrall", 8'h00, 8'h00, 1'b0, 3'd0); exp_b("clrall", 8'h00, 8'h00, 1'b0, 3'd0);
        cyc();
        a_clr = '0; b_clr = '0;

        // edge mode: sensor[0] held 10 cycles, ack during cycle 3
        b_sensor = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            exp_b($sformatf("edge%0d", k), (k <= 3) ? 8'h01 : 8'h00, 8'h00,
                  (k <= 3) ? 1'b1 : 1'b0, 3'd0);
            cyc();
            b_ack = (k == 3);
        end
        b_ack = 1'b0; b_sensor = '0;

        // level mode: held high re-arms after one cleared cycle
        a_sensor = 8'h01;
        exp_a("lvl_set", 8'h01, 8'h00, 1'b1, 3'd0); cyc();
        a_ack = 1'b1;
        exp_a("lvl_ack", 8'h00, 8'h00, 1'b0, 3'd0); cyc();
        a_ack = 1'b0;
        exp_a("lvl_rearm", 8'h01, 8'h00, 1'b1, 3'd0); cyc();
        a_sensor = '0; a_clr = 8'h01;
        exp_a("lvl_clr", 8'h00, 8'h00, 1'b0, 3'd0); cyc();
        a_clr = '0;

        // priority and ack-by-ID
        a_sensor = 8'h24;
        exp_a("prio", 8'h24, 8'h00, 1'b1, 3'd2); cyc();
        a_sensor = '0; a_ack = 1'b1;
        exp_a("ack1", 8'h20, 8'h00, 1'b1, 3'd5); cyc();
        exp_a("ack2", 8'h00, 8'h00, 1'b0, 3'd0); cyc();
        a_ack = 1'b0;

        // masking
        a_sensor = 8'h42;
        exp_a("m_set", 8'h42, 8'h00, 1'b1, 3'd1); cyc();
        a_sensor = '0; a_mask = 8'h02;
        exp_a("m_02", 8'h42, 8'h00, 1'b1, 3'd6); settle();
        a_mask = 8'h42;
        exp_a("m_42", 8'h42, 8'h00, 1'b0, 3'd0); settle();
        a_ack = 1'b1;
        exp_a("m_ack", 8'h42, 8'h00, 1'b0, 3'd0); cyc();
        a_ack = 1'b0; a_mask = '0; a_clr = 8'h42;
        exp_a("m_clr", 8'h00, 8'h00, 1'b0, 3'd0); cyc();
        a_clr = '0;

        // overrun
        a_sensor = 8'h08;
        exp_a("o_set", 8'h08, 8'h00, 1'b1, 3'd3); cyc();
        exp_a("o_ovr", 8'h08, 8'h08, 1'b1, 3'd3); cyc();
        a_clr = 8'h08;
        exp_a("o_clrev", 8'h00, 8'h08, 1'b0, 3'd0); cyc();
        a_sensor = '0; a_clr = '0; a_ovr_clr = 1'b1;
        exp_a("o_oclr", 8'h00, 8'h00, 1'b0, 3'd0); cyc();
        a_ovr_clr = 1'b0; a_sensor = 8'h08;
        exp_a("o_set2", 8'h08, 8'h00, 1'b1, 3'd3); cyc();
        a_ovr_clr = 1'b1;
        exp_a("o_setwin", 8'h08, 8'h08, 1'b1, 3'd3); cyc();
        a_sensor = '0;
        exp_a("o_oclr2", 8'h08, 8'h00, 1'b1, 3'd3); cyc();
        a_ovr_clr = 1'b0; a_clr = 8'h08;
        exp_a("o_clr", 8'h00, 8'h00, 1'b0, 3'd0); cyc();
        a_clr = '0;

        // reset in mid-operation
        a_sensor = 8'h10;
        exp_a("g_10", 8'h10, 8'h00, 1'b1, 3'd4); cyc();
        a_sensor = 8'hFF;
        exp_a("g_ff", 8'hFF, 8'h10, 1'b1, 3'd0); cyc();
        grst = 1'b1;
        exp_a("g_force", 8'hFF, 8'h10, 1'b0, 3'd0); settle();
        exp_a("g_edge", 8'h00, 8'h00, 1'b0, 3'd0); exp_b("g_edge", 8'h00, 8'h00, 1'b0, 3'd0);
        cyc();
        grst = 1'b0; a_sensor = 8'h04;
        exp_a("g_resume", 8'h04, 8'h00, 1'b1, 3'd2); cyc();
        a_sensor = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
